// File: rtl/tnn_pkg.sv
// Shared types and constants for the TNN feature packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tnn_pkg;

  localparam int N_FEAT = 7;
  localparam int RAW_W  = 8;
  localparam int Q_W    = 2;
  localparam int VEC_W  = N_FEAT * Q_W;

  // Power-up thresholds split the 8-bit range into four equal bins.
  localparam logic [RAW_W-1:0] THR_RST0 = 8'd64;
  localparam logic [RAW_W-1:0] THR_RST1 = 8'd128;
  localparam logic [RAW_W-1:0] THR_RST2 = 8'd192;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAIN   = 2'd1,
    HOLD    = 2'd2
  } pack_state_t;

  typedef logic [RAW_W-1:0] thr_t [3];

endpackage

// File: rtl/tnn_quantizer.sv
// Maps one raw sample to a 2-bit level by counting thresholds it meets or exceeds.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_x raw sample, i_t0..i_t2 thresholds, o_q level 0..3.
module tnn_quantizer
  import tnn_pkg::*;
(
  input  logic [RAW_W-1:0] i_x,
  input  logic [RAW_W-1:0] i_t0,
  input  logic [RAW_W-1:0] i_t1,
  input  logic [RAW_W-1:0] i_t2,
  output logic [Q_W-1:0]   o_q
);

  logic [Q_W-1:0] w_c0;
  logic [Q_W-1:0] w_c1;
  logic [Q_W-1:0] w_c2;

  // Each term is 0/1, so the sum tops out at 3 and never wraps; threshold
  // ordering does not matter.
  assign w_c0 = {1'b0, (i_x >= i_t0)};
  assign w_c1 = {1'b0, (i_x >= i_t1)};
  assign w_c2 = {1'b0, (i_x >= i_t2)};
  assign o_q  = w_c0 + w_c1 + w_c2;

endmodule

// File: rtl/tnn_feature_packer.sv
// Collects 7 raw samples, quantizes each to 2 bits, presents one packed vector.
// Latency: m_valid rises the cycle after the last accepted beat; N_FEAT+1 cycle minimum period.
// Backpressure: s_ready drops while a vector is held; held vector is stable until m_ready.
// Ports: s_* raw sample stream, thr_* threshold write port, m_* packed vector out,
//        err_len one-cycle pulse on a short or over-long vector.
module tnn_feature_packer
  import tnn_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [RAW_W-1:0]        s_data,
  input  logic                    s_last,
  input  logic                    thr_we,
  input  logic [2:0]              thr_feat,
  input  logic [1:0]              thr_sel,
  input  logic [RAW_W-1:0]        thr_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [N_FEAT*Q_W-1:0]   m_feat,
  output logic                    err_len
);

  pack_state_t     r_state;
  pack_state_t     w_state_nxt;
  logic [2:0]      r_cnt;
  logic [VEC_W-1:0] r_vec;
  logic            r_err;
  thr_t            r_thr [N_FEAT];
  thr_t            w_thr_cur;
  logic [Q_W-1:0]  w_q;
  logic            w_acc;
  logic            w_last_slot;

  assign w_acc       = s_valid & s_ready;
  assign w_last_slot = (r_cnt == 3'(N_FEAT - 1));

  // Thresholds of the feature currently being collected.
  always_comb begin
    w_thr_cur = r_thr[0];
    for (int k = 1; k < N_FEAT; k++) begin
      if (r_cnt == 3'(k)) begin
        w_thr_cur = r_thr[k];
      end
    end
  end

  tnn_quantizer u_quant (
    .i_x  (s_data),
    .i_t0 (w_thr_cur[0]),
    .i_t1 (w_thr_cur[1]),
    .i_t2 (w_thr_cur[2]),
    .o_q  (w_q)
  );

  // Threshold register file. Out-of-range feature or select writes are dropped.
  // A beat accepted alongside a write still sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_FEAT; k++) begin
        r_thr[k][0] <= THR_RST0;
        r_thr[k][1] <= THR_RST1;
        r_thr[k][2] <= THR_RST2;
      end
    end else if (thr_we) begin
      for (int k = 0; k < N_FEAT; k++) begin
        for (int j = 0; j < 3; j++) begin
          if (thr_feat == 3'(k) && thr_sel == 2'(j)) begin
            r_thr[k][j] <= thr_data;
          end
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      COLLECT: begin
        if (w_acc && w_last_slot) begin
          w_state_nxt = s_last ? HOLD : DRAIN;
        end
      end
      DRAIN: begin
        if (w_acc && s_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) begin
          w_state_nxt = COLLECT;
        end
      end
      default: w_state_nxt = COLLECT;
    endcase
  end

  // FSM outputs.
  always_comb begin
    s_ready = (r_state != HOLD);
    m_valid = (r_state == HOLD);
  end

  // Slot counter, vector assembly and length-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 3'd0;
      r_vec <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == COLLECT && w_acc) begin
        for (int k = 0; k < N_FEAT; k++) begin
          if (r_cnt == 3'(k)) begin
            r_vec[k*Q_W +: Q_W] <= w_q;
          end
        end
        if (w_last_slot) begin
          // Full vector kept; missing s_last means extra beats follow (DRAIN).
          r_cnt <= 3'd0;
          r_err <= ~s_last;
        end else if (s_last) begin
          // Short vector: partial slots are simply overwritten by the next one.
          r_cnt <= 3'd0;
          r_err <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 3'd1;
        end
      end else if (r_state == HOLD && m_ready) begin
        r_cnt <= 3'd0;
      end
    end
  end

  assign m_feat  = r_vec;
  assign err_len = r_err;

endmodule
